// File: rtl/ahb_to_apb_bridge_pkg.sv
// AHB-Lite / APB codes and bridge FSM encoding shared by the bridge and its strobe generator.
package ahb_to_apb_bridge_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_RESP   = 3'd3,
      ST_ERR1   = 3'd4,
      ST_ERR2   = 3'd5
   } bridge_state_e;

   // AHB HPROT[0] = data (not opcode), HPROT[1] = privileged; APB PPROT = {instr, secure, priv}.
   function automatic logic [2:0] ahb_to_pprot(input logic [1:0] hprot_lo);
      return {~hprot_lo[0], 1'b0, hprot_lo[1]};
   endfunction

endpackage

// File: rtl/apb_strb_gen.sv
// Combinational HSIZE/HADDR[1:0]/HWRITE -> PSTRB decode plus misalignment flag; zero latency.
module apb_strb_gen
   import ahb_to_apb_bridge_pkg::*;
(
   input  logic [2:0] size_i,
   input  logic [1:0] addr_lo_i,
   input  logic       write_i,
   output logic [3:0] strb_o,
   output logic       misaligned_o
);

   always_comb begin
      strb_o       = 4'b0000;
      misaligned_o = 1'b0;
      case (size_i)
         HSIZE_BYTE: strb_o = 4'b0001 << addr_lo_i;
         HSIZE_HALF: begin
            strb_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
            misaligned_o = addr_lo_i[0];
         end
         HSIZE_WORD: begin
            strb_o       = 4'b1111;
            misaligned_o = |addr_lo_i;
         end
         default: misaligned_o = 1'b1;
      endcase
      // Reads and rejected transfers never assert byte lanes.
      if (!write_i || misaligned_o) begin
         strb_o = 4'b0000;
      end
   end

endmodule

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave converting single transfers into APB4 accesses, one in flight, with PREADY timeout.
// Accept at T: SETUP T+1, ACCESS T+2.., HREADYOUT back high the cycle after PREADY (or after error).
module ahb_to_apb_bridge
   import ahb_to_apb_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  HCLK_i,
   input  logic                  HRESETn_i,
   input  logic                  HSEL_i,
   input  logic [31:0]           HADDR_i,
   input  logic [1:0]            HTRANS_i,
   input  logic [2:0]            HSIZE_i,
   input  logic                  HWRITE_i,
   input  logic [3:0]            HPROT_i,
   input  logic [31:0]           HWDATA_i,
   input  logic                  HREADY_i,
   output logic                  HREADYOUT_o,
   output logic [1:0]            HRESP_o,
   output logic [31:0]           HRDATA_o,
   output logic [ADDR_WIDTH-1:0] PADDR_o,
   output logic                  PSEL_o,
   output logic                  PENABLE_o,
   output logic                  PWRITE_o,
   output logic [31:0]           PWDATA_o,
   output logic [3:0]            PSTRB_o,
   output logic [2:0]            PPROT_o,
   input  logic                  PREADY_i,
   input  logic                  PSLVERR_i,
   input  logic [31:0]           PRDATA_i
);

   localparam int CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

   bridge_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [3:0]            strb_q, strb_d;
   logic [2:0]            prot_q, prot_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  hreadyout_q, hreadyout_d;
   logic [1:0]            hresp_q, hresp_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;

   logic                  accept;
   logic [3:0]            strb_in;
   logic                  misaligned_in;
   logic                  unused_hi;

   assign unused_hi = ^{HADDR_i[31:ADDR_WIDTH], HPROT_i[3:2]};

   // HTRANS[1] covers NONSEQ and SEQ; IDLE/BUSY get a zero-wait OKAY with no capture.
   assign accept = HSEL_i & HREADY_i & HTRANS_i[1];

   apb_strb_gen u_strb_gen (
      .size_i       (HSIZE_i),
      .addr_lo_i    (HADDR_i[1:0]),
      .write_i      (HWRITE_i),
      .strb_o       (strb_in),
      .misaligned_o (misaligned_in)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      strb_d  = strb_q;
      prot_d  = prot_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;

      case (state_q)
         // Only states that present HREADYOUT = 1 may take a new address phase.
         ST_IDLE, ST_RESP, ST_ERR2: begin
            state_d = ST_IDLE;
            if (accept) begin
               addr_d  = HADDR_i[ADDR_WIDTH-1:0];
               write_d = HWRITE_i;
               strb_d  = strb_in;
               prot_d  = ahb_to_pprot(HPROT_i[1:0]);
               cnt_d   = '0;
               state_d = misaligned_in ? ST_ERR1 : ST_SETUP;
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (PREADY_i) begin
               if (PSLVERR_i) begin
                  state_d = ST_ERR1;
               end else begin
                  state_d = ST_RESP;
                  if (!write_q) begin
                     rdata_d = PRDATA_i;
                  end
               end
            end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
               state_d = ST_ERR1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase

      // Bus-facing controls are registered, decoded from the state being entered.
      hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_RESP) || (state_d == ST_ERR2);
      hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_d   = (state_d == ST_ACCESS);
   end

   always_ff @(posedge HCLK_i) begin
      if (!HRESETn_i) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         write_q     <= 1'b0;
         strb_q      <= 4'b0000;
         prot_q      <= 3'b000;
         rdata_q     <= 32'h0;
         cnt_q       <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         strb_q      <= strb_d;
         prot_q      <= prot_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
      end
   end

   assign HREADYOUT_o = hreadyout_q;
   assign HRESP_o     = hresp_q;
   assign HRDATA_o    = rdata_q;
   assign PADDR_o     = addr_q;
   assign PSEL_o      = psel_q;
   assign PENABLE_o   = penable_q;
   assign PWRITE_o    = write_q;
   assign PSTRB_o     = strb_q;
   assign PPROT_o     = prot_q;
   // The master holds HWDATA while HREADYOUT is low, so it is stable across SETUP/ACCESS.
   assign PWDATA_o    = HWDATA_i;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Directed bench for ahb_to_apb_bridge (TIMEOUT = 4), sole slave on the bus so HREADY = HREADYOUT.
module tb_ahb_to_apb_bridge;

   logic        clk;
   logic        rst_n;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic        hreadyout;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic [15:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready;
   logic        pslverr;
   logic [31:0] prdata;

   int checks = 0;
   int passes = 0;

   ahb_to_apb_bridge #(.ADDR_WIDTH(16), .TIMEOUT(4)) dut (
      .HCLK_i      (clk),
      .HRESETn_i   (rst_n),
      .HSEL_i      (hsel),
      .HADDR_i     (haddr),
      .HTRANS_i    (htrans),
      .HSIZE_i     (hsize),
      .HWRITE_i    (hwrite),
      .HPROT_i     (hprot),
      .HWDATA_i    (hwdata),
      .HREADY_i    (hreadyout),
      .HREADYOUT_o (hreadyout),
      .HRESP_o     (hresp),
      .HRDATA_o    (hrdata),
      .PADDR_o     (paddr),
      .PSEL_o      (psel),
      .PENABLE_o   (penable),
      .PWRITE_o    (pwrite),
      .PWDATA_o    (pwdata),
      .PSTRB_o     (pstrb),
      .PPROT_o     (pprot),
      .PREADY_i    (pready),
      .PSLVERR_i   (pslverr),
      .PRDATA_i    (prdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [3:0] pr);
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
      hprot  = pr;
   endtask

   task automatic bus_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; hsel = 0; haddr = 0; htrans = 0; hsize = 0; hwrite = 0; hprot = 0;
      hwdata = 0; pready = 1; pslverr = 0; prdata = 0;
      tick(); tick(); #1;
      checks++; if ({hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pstrb, pprot} !== {1'b1, 2'b00, 32'h0, 3'b000, 16'h0, 4'h0, 3'h0})
         $display("FAIL reset_state got %h exp %h", {hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pstrb, pprot}, {1'b1, 2'b00, 32'h0, 3'b000, 16'h0, 4'h0, 3'h0}); else passes++;
      tick(); rst_n = 1'b1;
      // IDLE then BUSY with HSEL high: zero-wait OKAY, nothing captured
      hsel = 1; htrans = 2'b00; haddr = 32'h0000_FFFF; hwrite = 1; hsize = 3'b010;
      tick(); htrans = 2'b01; #1;
      checks++; if ({hreadyout, hresp, psel, paddr} !== {1'b1, 2'b00, 1'b0, 16'h0})
         $display("FAIL idle_trans got %h exp %h", {hreadyout, hresp, psel, paddr}, {1'b1, 2'b00, 1'b0, 16'h0}); else passes++;
      tick(); bus_idle(); #1;
      checks++; if ({hreadyout, hresp, psel, paddr} !== {1'b1, 2'b00, 1'b0, 16'h0})
         $display("FAIL busy_trans got %h exp %h", {hreadyout, hresp, psel, paddr}, {1'b1, 2'b00, 1'b0, 16'h0}); else passes++;
   endtask

   task automatic test_write_word();
      pready = 1; pslverr = 0;
      addr_phase(32'h0000_0104, 1'b1, 3'b010, 4'b0011);
      tick(); bus_idle(); hwdata = 32'hDEAD_BEEF; #1;
      checks++; if ({psel, penable, hreadyout} !== 3'b100)
         $display("FAIL wr_setup_ctl got %b exp 100", {psel, penable, hreadyout}); else passes++;
      checks++; if ({paddr, pstrb, pwrite, pprot, pwdata} !== {16'h0104, 4'b1111, 1'b1, 3'b001, 32'hDEAD_BEEF})
         $display("FAIL wr_setup_bus got %h exp %h", {paddr, pstrb, pwrite, pprot, pwdata}, {16'h0104, 4'b1111, 1'b1, 3'b001, 32'hDEAD_BEEF}); else passes++;
      tick(); #1;
      checks++; if ({psel, penable, hreadyout, paddr, pstrb} !== {3'b110, 16'h0104, 4'b1111})
         $display("FAIL wr_access got %h exp %h", {psel, penable, hreadyout, paddr, pstrb}, {3'b110, 16'h0104, 4'b1111}); else passes++;
      tick(); #1;
      checks++; if ({psel, penable, hreadyout, hresp} !== 5'b00100)
         $display("FAIL wr_resp got %b exp 00100", {psel, penable, hreadyout, hresp}); else passes++;
      tick(); #1;
   endtask

   task automatic test_read_wait();
      pready = 0; prdata = 32'hFFFF_FFFF;
      addr_phase(32'h0000_0203, 1'b0, 3'b000, 4'b0000);
      tick(); bus_idle(); #1;
      checks++; if ({psel, penable, hreadyout, paddr, pstrb, pwrite, pprot} !== {3'b100, 16'h0203, 4'b0000, 1'b0, 3'b100})
         $display("FAIL rd_setup got %h exp %h", {psel, penable, hreadyout, paddr, pstrb, pwrite, pprot}, {3'b100, 16'h0203, 4'b0000, 1'b0, 3'b100}); else passes++;
      for (int c = 2; c <= 4; c++) begin
         tick();
         if (c == 3) addr_phase(32'h0000_0300, 1'b1, 3'b010, 4'b0000);
         if (c == 4) bus_idle();
         #1;
         checks++; if ({psel, penable, hreadyout, paddr} !== {3'b110, 16'h0203})
            $display("FAIL rd_wait_%0d got %h exp %h", c, {psel, penable, hreadyout, paddr}, {3'b110, 16'h0203}); else passes++;
      end
      tick(); pready = 1; prdata = 32'h1122_3344; #1;
      checks++; if ({psel, penable, hreadyout, hrdata} !== {3'b110, 32'h0})
         $display("FAIL rd_last_access got %h exp %h", {psel, penable, hreadyout, hrdata}, {3'b110, 32'h0}); else passes++;
      tick(); prdata = 32'h0; #1;
      checks++; if ({hreadyout, hresp, psel, hrdata} !== {1'b1, 2'b00, 1'b0, 32'h1122_3344})
         $display("FAIL rd_resp got %h exp %h", {hreadyout, hresp, psel, hrdata}, {1'b1, 2'b00, 1'b0, 32'h1122_3344}); else passes++;
      tick(); #1;
   endtask

   task automatic test_slverr();
      pready = 1; pslverr = 1;
      addr_phase(32'h0000_0008, 1'b1, 3'b010, 4'b0000);
      tick(); bus_idle(); hwdata = 32'h5555_AAAA;
      tick(); #1;
      checks++; if ({psel, penable} !== 2'b11)
         $display("FAIL err_access got %b exp 11", {psel, penable}); else passes++;
      tick(); pslverr = 0; #1;
      checks++; if ({hreadyout, hresp, psel, penable} !== 5'b00100)
         $display("FAIL err_err1 got %b exp 00100", {hreadyout, hresp, psel, penable}); else passes++;
      tick(); #1;
      checks++; if ({hreadyout, hresp, psel, hrdata} !== {1'b1, 2'b01, 1'b0, 32'h1122_3344})
         $display("FAIL err_err2 got %h exp %h", {hreadyout, hresp, psel, hrdata}, {1'b1, 2'b01, 1'b0, 32'h1122_3344}); else passes++;
      tick(); #1;
      checks++; if ({hreadyout, hresp} !== 3'b100)
         $display("FAIL err_idle got %b exp 100", {hreadyout, hresp}); else passes++;
   endtask

   task automatic test_misaligned();
      pready = 1;
      addr_phase(32'h0000_0002, 1'b1, 3'b010, 4'b0000);
      tick(); bus_idle(); #1;
      checks++; if ({psel, hreadyout, hresp} !== 4'b0001)
         $display("FAIL mis_err1 got %b exp 0001", {psel, hreadyout, hresp}); else passes++;
      tick(); #1;
      checks++; if ({psel, hreadyout, hresp} !== 4'b0101)
         $display("FAIL mis_err2 got %b exp 0101", {psel, hreadyout, hresp}); else passes++;
      tick(); #1;
      checks++; if ({psel, hreadyout, hresp} !== 4'b0100)
         $display("FAIL mis_idle got %b exp 0100", {psel, hreadyout, hresp}); else passes++;
   endtask

   task automatic test_strobes();
      logic [31:0] s_addr [4] = '{32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 32'h0000_0003};
      logic [2:0]  s_size [4] = '{3'b001, 3'b000, 3'b001, 3'b000};
      logic [3:0]  s_strb [4] = '{4'b1100, 4'b0010, 4'b0011, 4'b1000};
      pready = 1;
      for (int i = 0; i < 4; i++) begin
         addr_phase(s_addr[i], 1'b1, s_size[i], 4'b0000);
         tick(); bus_idle(); #1;
         checks++; if ({psel, pstrb} !== {1'b1, s_strb[i]})
            $display("FAIL strb_%0d got %b exp %b", i, {psel, pstrb}, {1'b1, s_strb[i]}); else passes++;
         tick(); tick(); tick(); #1;
      end
   endtask

   task automatic test_timeout();
      pready = 0;
      addr_phase(32'h0000_0040, 1'b1, 3'b010, 4'b0000);
      tick(); bus_idle(); #1;
      checks++; if ({psel, penable, hreadyout} !== 3'b100)
         $display("FAIL to_setup got %b exp 100", {psel, penable, hreadyout}); else passes++;
      for (int c = 2; c <= 5; c++) begin
         tick(); #1;
         checks++; if ({psel, penable, hreadyout} !== 3'b110)
            $display("FAIL to_access_%0d got %b exp 110", c, {psel, penable, hreadyout}); else passes++;
      end
      tick(); #1;
      checks++; if ({psel, penable, hreadyout, hresp} !== 5'b00001)
         $display("FAIL to_err1 got %b exp 00001", {psel, penable, hreadyout, hresp}); else passes++;
      tick(); #1;
      checks++; if ({psel, penable, hreadyout, hresp} !== 5'b00101)
         $display("FAIL to_err2 got %b exp 00101", {psel, penable, hreadyout, hresp}); else passes++;
      tick(); #1;
      checks++; if ({psel, hreadyout, hresp} !== 4'b0100)
         $display("FAIL to_idle got %b exp 0100", {psel, hreadyout, hresp}); else passes++;
      pready = 1;
   endtask

   task automatic test_back_to_back();
      pready = 1;
      addr_phase(32'h0000_0010, 1'b1, 3'b010, 4'b0000);
      tick(); bus_idle(); hwdata = 32'hA5A5_5A5A;
      tick();
      tick(); addr_phase(32'h0000_0020, 1'b0, 3'b010, 4'b0010); pready = 0; #1;
      checks++; if ({hreadyout, hresp, psel} !== 4'b1000)
         $display("FAIL b2b_resp got %b exp 1000", {hreadyout, hresp, psel}); else passes++;
      tick(); bus_idle(); #1;
      checks++; if ({psel, penable, hreadyout, paddr, pwrite, pprot} !== {3'b100, 16'h0020, 1'b0, 3'b101})
         $display("FAIL b2b_setup got %h exp %h", {psel, penable, hreadyout, paddr, pwrite, pprot}, {3'b100, 16'h0020, 1'b0, 3'b101}); else passes++;
      tick(); rst_n = 1'b0; #1;
      checks++; if ({psel, penable, hreadyout} !== 3'b110)
         $display("FAIL b2b_access got %b exp 110", {psel, penable, hreadyout}); else passes++;
      tick(); #1;
      checks++; if ({psel, penable, hreadyout, hresp, hrdata, paddr} !== {5'b00100, 32'h0, 16'h0})
         $display("FAIL b2b_reset got %h exp %h", {psel, penable, hreadyout, hresp, hrdata, paddr}, {5'b00100, 32'h0, 16'h0}); else passes++;
      rst_n = 1'b1; pready = 1;
      tick(); #1;
      checks++; if ({psel, hreadyout} !== 2'b01)
         $display("FAIL b2b_post got %b exp 01", {psel, hreadyout}); else passes++;
   endtask

   initial begin
      test_reset();
      test_write_word();
      test_read_wait();
      test_slverr();
      test_misaligned();
      test_strobes();
      test_timeout();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
